demux1_to_4_32bit_reg: RTL and testbench
========================================

# demux1_to_4_32bit_reg

Registered 1-to-4 demultiplexer for 32-bit words, the distribution counterpart to the 4:1 32-bit datapath mux. A single valid/ready input stream is steered by a 2-bit select into one of four output channels. Each channel has a one-entry holding register with its own valid/ready handshake, plus a saturating per-channel word counter for debug readback. The block sits between a shared producer and up to four independent consumers.

## Interface
Parameters:
- WIDTH, 32, data word width
- CNT_W, 16, width of each per-channel word counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  input word
- in_sel  input  2  destination channel (0..3), sampled with in_data
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle (combinational)
- out_data  output  4*WIDTH  channel n occupies bits [n*WIDTH +: WIDTH], registered
- out_valid  output  4  per-channel holding register full
- out_ready  input  4  per-channel consumer accepts
- cnt_clr  input  1  synchronous clear of all counters
- word_cnt  output  4*CNT_W  channel n count at bits [n*CNT_W +: CNT_W]

## Operation
- Accept: acc = in_valid & in_ready.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel]. It depends only on the selected channel, so a stalled channel never blocks traffic to other channels.
- On acc:
  - out_data[in_sel] <= in_data.
  - out_valid[in_sel] <= 1.
- Channel n drain: if out_valid[n] & out_ready[n] and no acc to n, then out_valid[n] <= 0. out_data[n] holds its last value and is not zeroed.
- Simultaneous drain and acc on the same channel: the new word replaces the old one and out_valid stays 1. Full throughput is one word per cycle per channel.
- While out_valid[n] & ~out_ready[n], out_data[n] and out_valid[n] are held stable.
- Only the selected channel changes on acc. Non-selected channels are unaffected by in_data and in_sel.
- Counters:
  - word_cnt[n] increments by 1 on each acc with in_sel==n.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 sets all counters to 0. If acc occurs in the same cycle, the selected counter becomes 1, not 0.
- When in_valid=0, in_sel and in_data are don't-care and cause no state change.

## Timing
- Reset (rst_n=0, asynchronous assert): out_valid=4'b0000, out_data all 0, word_cnt all 0. in_ready then evaluates to 1 for any in_sel.
- Reset deassertion is synchronous to clk. The first accept is possible on the first rising edge after rst_n=1.
- Reset mid-operation discards held words immediately, with no handshake completion.
- Latency: a word accepted at edge k appears on out_data[in_sel] with out_valid set after edge k. Consumer can take it at edge k+1.
- Counter update lands on the same edge as the accept.
- No combinational path from in_valid to out_valid.
- The combinational path out_ready -> in_ready is allowed; the producer must not make in_valid depend on in_ready.

## Test plan
- Reset and fanout: after reset, send FFFFFFFF/sel0, AAAAAAAA/sel1, 00000000/sel2, 11111111/sel3 on consecutive cycles with out_ready=4'b1111.
  - Each word appears one cycle later on its channel only.
  - word_cnt = {1,1,1,1}.
  - out_valid pulses one cycle per channel.
- Backpressure isolation: out_ready[1]=0; send AAAAAAAA/sel1, then 12345678/sel1, then 11111111/sel3.
  - in_ready drops on the second sel1 word; out_data[1] stays AAAAAAAA.
  - The sel3 word is accepted with in_ready=1 and appears on channel 3.
  - After out_ready[1]=1, channel 1 drains and the second sel1 word is accepted.
- Back-to-back streaming: 8 words 0..7 to sel2 with out_ready[2]=1 held.
  - in_ready=1 every cycle; channel 2 presents 0..7 on consecutive cycles.
  - word_cnt[2]=8.
- Counter saturation and clear, with CNT_W=4:
  - 17 accepts to sel0 leave word_cnt[0]=15.
  - cnt_clr plus an accept to sel0 in the same cycle gives word_cnt[0]=1 and all others 0.
- Asynchronous reset mid-stream: with channels 0 and 3 holding words and out_ready=0, pulse rst_n low between clock edges.
  - out_valid=0 and all counts 0 immediately, before the next edge.
  - Traffic resumes normally after release.

Source files
------------

// File: rtl/demux1_to_4_32bit_reg.sv
// Registered 1:4 demultiplexer: one valid/ready input stream steered by in_sel
// into four one-entry channel registers, each with a saturating word counter.
module demux1_to_4_32bit_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    input  logic                 cnt_clr,
    output logic [4*CNT_W-1:0]   word_cnt
);

    logic acc;

    // Ready looks only at the selected channel, so a stalled consumer never
    // blocks traffic headed for the other three.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign acc      = in_valid & in_ready;

    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        logic             acc_n;
        logic [WIDTH-1:0] data_q,  data_d;
        logic             valid_q, valid_d;
        logic [CNT_W-1:0] cnt_q,   cnt_d;

        assign acc_n = acc && (in_sel == 2'(gi));

        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            if (acc_n) begin
                data_d  = in_data;
                valid_d = 1'b1;
            end else if (valid_q && out_ready[gi]) begin
                valid_d = 1'b0;
            end
        end

        // A clear coinciding with an accept still counts that accept.
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr)
                cnt_d = acc_n ? CNT_W'(1) : '0;
            else if (acc_n && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + CNT_W'(1);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
                cnt_q   <= cnt_d;
            end
        end

        assign out_data[gi*WIDTH +: WIDTH] = data_q;
        assign out_valid[gi]               = valid_q;
        assign word_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_demux1_to_4_32bit_reg.sv
// Directed bench for demux1_to_4_32bit_reg, built with 4-bit counters so that
// saturation is reachable in a few cycles.
module tb_demux1_to_4_32bit_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [WIDTH-1:0]     in_data;
    logic [1:0]           in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*WIDTH-1:0]   out_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic                 cnt_clr;
    logic [4*CNT_W-1:0]   word_cnt;

    int errors = 0;
    int checks = 0;

    demux1_to_4_32bit_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0;
        out_ready = 4'h0; cnt_clr = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", out_data); end
        checks++;
        if (word_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %h expected 0", word_cnt); end
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready sel%0d: got %b expected 1", s, in_ready); end
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_fanout();
        logic [WIDTH-1:0] w [4];
        w[0] = 32'hFFFFFFFF; w[1] = 32'hAAAAAAAA; w[2] = 32'h00000000; w[3] = 32'h11111111;
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_data = w[i]; in_sel = 2'(i); in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL fanout_ready%0d: got %b expected 1", i, in_ready); end
            step();
            checks++;
            if (out_valid !== 4'(1 << i)) begin errors++; $display("FAIL fanout_valid%0d: got %b expected %b", i, out_valid, 4'(1 << i)); end
            checks++;
            if (out_data[i*WIDTH +: WIDTH] !== w[i]) begin errors++; $display("FAIL fanout_data%0d: got %h expected %h", i, out_data[i*WIDTH +: WIDTH], w[i]); end
            $display("fanout: sel=%0d data=%h valid=%b", i, w[i], out_valid);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL fanout_drain: got %b expected 0000", out_valid); end
        checks++;
        if (out_data !== 128'h11111111_00000000_AAAAAAAA_FFFFFFFF) begin errors++; $display("FAIL fanout_hold: got %h expected 11111111_00000000_aaaaaaaa_ffffffff", out_data); end
        checks++;
        if (word_cnt !== 16'h1111) begin errors++; $display("FAIL fanout_cnt: got %h expected 1111", word_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        in_data = 32'hAAAAAAAA; in_sel = 2'd1; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first: got %b expected 1", in_ready); end
        step();
        $display("backpressure: sel=1 data=aaaaaaaa valid=%b", out_valid);
        in_data = 32'h12345678;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall: got %b expected 0", in_ready); end
        step();
        $display("backpressure: sel=1 data=12345678 stalled valid=%b", out_valid);
        checks++;
        if (out_data[WIDTH +: WIDTH] !== 32'hAAAAAAAA || out_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h/%b expected aaaaaaaa/1", out_data[WIDTH +: WIDTH], out_valid[1]); end
        in_data = 32'h11111111; in_sel = 2'd3;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready: got %b expected 1", in_ready); end
        step();
        $display("backpressure: sel=3 data=11111111 valid=%b", out_valid);
        checks++;
        if (out_data[3*WIDTH +: WIDTH] !== 32'h11111111 || out_valid !== 4'b1010) begin errors++; $display("FAIL bp_other_data: got %h/%b expected 11111111/1010", out_data[3*WIDTH +: WIDTH], out_valid); end
        checks++;
        if (out_data[WIDTH +: WIDTH] !== 32'hAAAAAAAA) begin errors++; $display("FAIL bp_hold2: got %h expected aaaaaaaa", out_data[WIDTH +: WIDTH]); end
        out_ready = 4'b1111; in_data = 32'h12345678; in_sel = 2'd1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        step();
        $display("backpressure: released sel=1 data=12345678 valid=%b", out_valid);
        checks++;
        if (out_data[WIDTH +: WIDTH] !== 32'h12345678 || out_valid !== 4'b0010) begin errors++; $display("FAIL bp_release_data: got %h/%b expected 12345678/0010", out_data[WIDTH +: WIDTH], out_valid); end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain: got %b expected 0000", out_valid); end
        checks++;
        if (word_cnt !== 16'h2131) begin errors++; $display("FAIL bp_cnt: got %h expected 2131", word_cnt); end
    endtask

    task automatic test_back_to_back();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checks++;
        if (word_cnt !== 16'h0000) begin errors++; $display("FAIL clr_only: got %h expected 0000", word_cnt); end
        out_ready = 4'hF; in_sel = 2'd2; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'(i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, in_ready); end
            step();
            checks++;
            if (out_data[2*WIDTH +: WIDTH] !== 32'(i) || out_valid !== 4'b0100) begin errors++; $display("FAIL b2b_data%0d: got %h/%b expected %h/0100", i, out_data[2*WIDTH +: WIDTH], out_valid, 32'(i)); end
            $display("back_to_back: word=%0d ch2=%h valid=%b", i, out_data[2*WIDTH +: WIDTH], out_valid);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (word_cnt !== 16'h0800) begin errors++; $display("FAIL b2b_cnt: got %h expected 0800", word_cnt); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_c;
        out_ready = 4'hF; in_sel = 2'd0; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 32'h5A00_0000 + 32'(i);
            step();
            exp_c = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            checks++;
            if (word_cnt[3:0] !== exp_c) begin errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, word_cnt[3:0], exp_c); end
            $display("saturation: accept=%0d cnt0=%0d", i + 1, word_cnt[3:0]);
        end
        checks++;
        if (word_cnt !== 16'h080F) begin errors++; $display("FAIL sat_all: got %h expected 080f", word_cnt); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0; in_valid = 1'b0;
        $display("saturation: clear+accept cnt=%h", word_cnt);
        checks++;
        if (word_cnt !== 16'h0001) begin errors++; $display("FAIL clr_acc: got %h expected 0001", word_cnt); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 4'h0; in_valid = 1'b1;
        in_data = 32'hDEADBEEF; in_sel = 2'd0;
        step();
        in_data = 32'hCAFEF00D; in_sel = 2'd3;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 4'b1001 || word_cnt !== 16'h1002) begin errors++; $display("FAIL ar_pre: got %b/%h expected 1001/1002", out_valid, word_cnt); end
        #2 rst_n = 1'b0;
        #1;
        $display("async_reset: mid-cycle valid=%b cnt=%h", out_valid, word_cnt);
        checks++;
        if (out_valid !== 4'b0000) begin errors++; $display("FAIL ar_valid: got %b expected 0000", out_valid); end
        checks++;
        if (word_cnt !== 16'h0000 || out_data !== '0) begin errors++; $display("FAIL ar_state: got cnt=%h data=%h expected 0/0", word_cnt, out_data); end
        #2 rst_n = 1'b1;
        out_ready = 4'hF; in_data = 32'h55555555; in_sel = 2'd2; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        $display("async_reset: resume ch2=%h valid=%b", out_data[2*WIDTH +: WIDTH], out_valid);
        checks++;
        if (out_data[2*WIDTH +: WIDTH] !== 32'h55555555 || out_valid !== 4'b0100 || word_cnt !== 16'h0100) begin errors++; $display("FAIL ar_resume: got %h/%b/%h expected 55555555/0100/0100", out_data[2*WIDTH +: WIDTH], out_valid, word_cnt); end
    endtask

    initial begin
        test_reset();
        test_fanout();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
